// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 data mux.
// Optional per-owner hold limit enabled by defining ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic [1:0]       s,
  output logic             valid,
  output logic [WIDTH-1:0] o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r;
  logic [1:0]       ptr_r;
  logic [3:0]       gnt_r;
  logic [1:0]       s_r;
  logic             valid_r;

  logic [2:0]       pick_s;
  logic             owner_req_s;
  logic             preempt_s;
  logic             keep_s;
  logic [WIDTH-1:0] sel_data_s;

  if (MAX_HOLD < 1) begin : g_max_hold_check
    $error("mux4_rr_arbiter: MAX_HOLD must be >= 1");
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);

  logic [HW-1:0] hold_cnt_r;
  logic          others_s;
  logic          at_limit_s;
`endif

  // First requester at or after start (mod 4); returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] start);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    // Walk the offsets from farthest to nearest so the nearest requester wins.
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req_v[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Arbitration decision for the coming edge.
  always_comb begin
    pick_s      = rr_pick(req, ptr_r);
    owner_req_s = req[s_r];
`ifdef ARB_HOLD_LIMIT_EN
    others_s    = |(req & ~gnt_r);
    at_limit_s  = (hold_cnt_r == HOLD_LAST);
    preempt_s   = at_limit_s & others_s;
`else
    preempt_s   = 1'b0;
`endif
    keep_s      = owner_req_s & ~preempt_s;
  end

  // Arbiter FSM with registered grant, select and valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd0;
      gnt_r      <= 4'b0000;
      s_r        <= 2'd0;
      valid_r    <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_r <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_s[2]) begin
            state_r    <= GRANT;
            gnt_r      <= onehot(pick_s[1:0]);
            s_r        <= pick_s[1:0];
            valid_r    <= 1'b1;
            ptr_r      <= pick_s[1:0] + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_r <= '0;
`endif
          end
        end
        GRANT: begin
          if (keep_s) begin
`ifdef ARB_HOLD_LIMIT_EN
            // Nobody else waiting at the limit: start a fresh hold window.
            if (at_limit_s) begin
              hold_cnt_r <= '0;
            end else if (hold_cnt_r != HOLD_SAT) begin
              hold_cnt_r <= hold_cnt_r + HW'(1);
            end
`endif
          end else if (pick_s[2]) begin
            gnt_r      <= onehot(pick_s[1:0]);
            s_r        <= pick_s[1:0];
            valid_r    <= 1'b1;
            ptr_r      <= pick_s[1:0] + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_r <= '0;
`endif
          end else begin
            // Release with no contender: s keeps the last owner.
            state_r    <= IDLE;
            gnt_r      <= 4'b0000;
            valid_r    <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_r <= '0;
`endif
          end
        end
        default: begin
          state_r    <= IDLE;
          gnt_r      <= 4'b0000;
          valid_r    <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_r <= '0;
`endif
        end
      endcase
    end
  end

  // Shared 4:1 data path, forced to zero while idle.
  always_comb begin
    case (s_r)
      2'd0:    sel_data_s = a;
      2'd1:    sel_data_s = b;
      2'd2:    sel_data_s = c;
      2'd3:    sel_data_s = d;
      default: sel_data_s = {WIDTH{1'b0}};
    endcase
    if (valid_r) begin
      o = sel_data_s;
    end else begin
      o = {WIDTH{1'b0}};
    end
  end

  assign gnt   = gnt_r;
  assign s     = s_r;
  assign valid = valid_r;

endmodule
